// File: rtl/ram2_pkg.sv
// Shared types and default geometry for the ram2 bus master.
package ram2_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD0  = 3'd2,
        ST_RD1  = 3'd3,
        ST_FILL = 3'd4
    } state_e;

endpackage

// File: rtl/ram2.sv
// 32 x 32 single-port RAM with a shared bidirectional data bus and registered read.
module ram2 #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              ena,
    input  logic              wena,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data
);

    logic [DATA_W-1:0] r_mem [1 << ADDR_W];
    logic [DATA_W-1:0] r_dout;
    logic              r_drive;

    always_ff @(posedge clk) begin
        if (ena && wena) begin
            r_mem[addr] <= data;
        end
        if (ena && !wena) begin
            r_dout <= r_mem[addr];
        end
        // The RAM keeps driving for one cycle after its last read cycle.
        r_drive <= ena & ~wena;
    end

    assign data = r_drive ? r_dout : {DATA_W{1'bz}};

endmodule

// File: rtl/ram2_ctrl.sv
// Request-stream to ram2 bus master: single-word read/write, bulk fill, tristate data bus owner.
module ram2_ctrl
    import ram2_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_pattern,
    output logic              fill_done,
    output logic              busy,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e            r_state;
    logic              r_ram_ena;
    logic              r_ram_wena;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_pattern;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_fill_done;

    logic [DATA_W-1:0] w_fill_data;
    logic [DATA_W-1:0] w_drive_data;
    logic              w_drive_en;

    assign w_fill_data  = r_pattern + DATA_W'(r_fill_cnt);
    assign w_drive_data = (r_state == ST_FILL) ? w_fill_data : r_wdata;
    assign w_drive_en   = r_ram_ena & r_ram_wena;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ram_ena   <= 1'b0;
            r_ram_wena  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_pattern   <= '0;
            r_fill_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_fill_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // Fill wins over a simultaneous request, which stays pending.
                    if (fill_start) begin
                        r_state    <= ST_FILL;
                        r_ram_ena  <= 1'b1;
                        r_ram_wena <= 1'b1;
                        r_addr     <= '0;
                        r_fill_cnt <= '0;
                        r_pattern  <= fill_pattern;
                    end else if (req_valid) begin
                        r_state    <= req_we ? ST_WR : ST_RD0;
                        r_ram_ena  <= 1'b1;
                        r_ram_wena <= req_we;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                    end
                end
                ST_WR: begin
                    r_state    <= ST_IDLE;
                    r_ram_ena  <= 1'b0;
                    r_ram_wena <= 1'b0;
                end
                ST_RD0: begin
                    r_state <= ST_RD1;
                end
                ST_RD1: begin
                    r_state     <= ST_IDLE;
                    r_ram_ena   <= 1'b0;
                    r_ram_wena  <= 1'b0;
                    r_rdata     <= ram_data;
                    r_rsp_valid <= 1'b1;
                end
                ST_FILL: begin
                    if (r_fill_cnt == LAST_ADDR) begin
                        r_state     <= ST_IDLE;
                        r_ram_ena   <= 1'b0;
                        r_ram_wena  <= 1'b0;
                        r_fill_done <= 1'b1;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        r_addr     <= r_addr + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ram_ena  <= 1'b0;
                    r_ram_wena <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign fill_done = r_fill_done;
    assign ram_ena   = r_ram_ena;
    assign ram_wena  = r_ram_wena;
    assign ram_addr  = r_addr;
    assign ram_data  = w_drive_en ? w_drive_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram2_ctrl.sv
// Directed + randomized bench for ram2_ctrl driving ram2, checked against a word-array model.
module tb_ram2_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fill_start = 1'b0;
    logic [31:0] fill_pattern = '0;
    logic        fill_done;
    logic        busy;
    logic        ram_ena;
    logic        ram_wena;
    logic [4:0]  ram_addr;
    wire  [31:0] ram_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model_mem [32];
    bit          model_vld [32];

    always #5 clk = ~clk;

    ram2_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .fill_start(fill_start), .fill_pattern(fill_pattern), .fill_done(fill_done),
        .busy(busy), .ram_ena(ram_ena), .ram_wena(ram_wena),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    ram2 #(.ADDR_W(5), .DATA_W(32)) u_ram (
        .clk(clk), .ena(ram_ena), .wena(ram_wena), .addr(ram_addr), .data(ram_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 64 && req_ready !== 1'b1; i++) tick();
        chk("req_ready_wait", req_ready, 1);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
        chk("wr_ena", {ram_ena, ram_wena}, 2'b11);
        chk("wr_addr", ram_addr, a);
        chk("wr_bus", ram_data, d);
        chk("wr_ready", req_ready, 0);
        tick();
        chk("wr_gap_ena", ram_ena, 0);
        chk("wr_rsp", rsp_valid, 0);
        model_mem[a] = d;
        model_vld[a] = 1'b1;
        $display("write addr=%02h data=%08h", a, d);
    endtask

    task automatic do_read(input logic [4:0] a);
        logic [31:0] exp;
        exp = model_mem[a];
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0; req_addr = ~a;
        chk("rd0_ctl", {ram_ena, ram_wena, busy}, 3'b101);
        chk("rd0_addr", ram_addr, a);
        tick();
        chk("rd1_ctl", {ram_ena, ram_wena, rsp_valid}, 3'b100);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rdata", rsp_rdata, exp);
        chk("rd_gap_ena", ram_ena, 0);
        tick();
        chk("rd_rsp_pulse", rsp_valid, 0);
        chk("rd_rdata_hold", rsp_rdata, exp);
        $display("read  addr=%02h data=%08h expected=%08h", a, rsp_rdata, exp);
    endtask

    // Expects the fill to have been accepted at the previous edge.
    task automatic fill_body(input logic [31:0] p);
        for (int k = 0; k < 32; k++) begin
            chk("fill_ctl", {ram_ena, ram_wena, busy, fill_done}, 4'b1110);
            chk("fill_addr", ram_addr, k);
            chk("fill_bus", ram_data, p + k);
            model_mem[k] = p + k;
            model_vld[k] = 1'b1;
            tick();
        end
        chk("fill_done", fill_done, 1);
        chk("fill_gap_ena", ram_ena, 0);
        tick();
        chk("fill_done_pulse", fill_done, 0);
        $display("fill  pattern=%08h", p);
    endtask

    task automatic do_fill(input logic [31:0] p);
        wait_ready();
        fill_start = 1'b1; fill_pattern = p;
        tick();
        fill_start = 1'b0; fill_pattern = $urandom;
        fill_body(p);
    endtask

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;

        for (int i = 0; i < 32; i++) model_vld[i] = 1'b0;

        tick();
        chk("rst_ctl", {ram_ena, ram_wena, req_ready, busy}, 4'b0010);
        chk("rst_addr", ram_addr, 0);
        chk("rst_rsp", {rsp_valid, fill_done}, 2'b00);
        chk("rst_rdata", rsp_rdata, 0);
        tick();
        rst = 1'b0;
        $display("reset released");

        do_write(5'h00, 32'h12345678);
        do_read(5'h00);
        do_write(5'h01, 32'hA5A5A5A5);
        do_write(5'h1b, 32'h77777777);
        do_read(5'h01);
        do_read(5'h1b);

        for (int n = 0; n < 24; n++) begin
            a = 5'($urandom_range(0, 31));
            if (model_vld[a] && $urandom_range(0, 1) == 1) do_read(a);
            else do_write(a, $urandom);
        end

        do_fill(32'hFFFFFFF0);
        chk("fill_model_0", model_mem[0], 32'hFFFFFFF0);
        do_read(5'd0);
        do_read(5'd15);
        do_read(5'd16);
        do_read(5'd31);

        // Fill and read presented together: fill first, read stays pending.
        p = $urandom;
        a = 5'($urandom_range(0, 31));
        wait_ready();
        fill_start = 1'b1; fill_pattern = p;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        fill_start = 1'b0;
        chk("pend_ready", req_ready, 0);
        fill_body(p);
        // The pending read was accepted at the edge just passed.
        req_valid = 1'b0;
        chk("pend_rd0", {ram_ena, ram_wena, busy}, 3'b101);
        chk("pend_addr", ram_addr, a);
        tick();
        tick();
        chk("pend_rsp_valid", rsp_valid, 1);
        chk("pend_rdata", rsp_rdata, p + a);
        tick();
        $display("pending read addr=%02h data=%08h", a, rsp_rdata);

        // Reset during RD1.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd3;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrd_rsp", rsp_valid, 0);
        chk("rstrd_rdata", rsp_rdata, 0);
        chk("rstrd_ctl", {ram_ena, busy, req_ready}, 3'b001);
        tick();
        chk("rstrd_rsp2", rsp_valid, 0);
        $display("reset during RD1");

        // Reset as fill word 10 would start: words 0..9 new, 10..31 keep old values.
        p = 32'hC0DE0100;
        wait_ready();
        fill_start = 1'b1; fill_pattern = p;
        tick();
        fill_start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        chk("rstfill_addr9", ram_addr, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) model_mem[k] = p + k;
        chk("rstfill_done", fill_done, 0);
        chk("rstfill_ena", ram_ena, 0);
        tick();
        chk("rstfill_done2", fill_done, 0);
        $display("reset during fill");
        do_read(5'd0);
        do_read(5'd9);
        do_read(5'd10);
        do_read(5'd31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram2_ctrl.md
# ram2_ctrl

Single-port bus master sitting directly upstream of `ram2`, the 32 x 32-bit RAM with a bidirectional data bus. It converts a valid/ready request stream (single-word read or write) into `ram2` control cycles and owns the tristate data bus. It also provides a bulk fill command that initialises every word. Read data returns on a one-cycle response pulse.

## Interface
Parameters:
- `ADDR_W`, 5, RAM address width; depth is `1 << ADDR_W`.
- `DATA_W`, 32, RAM word width.

Ports:
- `clk`  in  1  rising-edge clock, shared with `ram2`.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle pulse: `rsp_rdata` is valid.
- `rsp_rdata`  out  DATA_W  read data; holds until the next read response.
- `fill_start`  in  1  start bulk fill (sampled only in IDLE).
- `fill_pattern`  in  DATA_W  fill base value.
- `fill_done`  out  1  one-cycle pulse when the fill completes.
- `busy`  out  1  high in every state except IDLE.
- `ram_ena`  out  1  to `ram2.ena`.
- `ram_wena`  out  1  to `ram2.wena`.
- `ram_addr`  out  ADDR_W  to `ram2.addr`.
- `ram_data`  inout  DATA_W  to `ram2.data`. Driven only when `ram_ena & ram_wena`; high-Z otherwise.

## Operation
- States:
  - IDLE: `ram_ena=0`, `req_ready=1`.
  - WR: `ena=1`, `wena=1`; 1 cycle.
  - RD0: `ena=1`, `wena=0`; 1 cycle.
  - RD1: `ena=1`, `wena=0`; capture `ram_data` at the end of this cycle.
  - FILL: `ena=1`, `wena=1`; 32 cycles.
- Transitions:
  - IDLE -> FILL on `fill_start`. Fill has priority over a simultaneous `req_valid`; that request is not accepted (`req_ready` is 1 but the handshake is ignored). It stays pending.
  - IDLE -> WR on `req_valid & req_we`.
  - IDLE -> RD0 on `req_valid & ~req_we`.
  - WR -> IDLE.
  - RD0 -> RD1 -> IDLE.
  - FILL -> IDLE after address 31 is written.
- Accepted request fields are registered; `ram_addr` and the driven data come from these registers, not from the live inputs.
- Fill behaviour:
  - A 5-bit counter starts at 0. Word k is written with `fill_pattern + k` (DATA_W modulo addition); `fill_pattern` is latched at start.
  - The counter stops at 31; no wrap to 0.
  - `fill_done` pulses in the cycle after the last write (first IDLE cycle).
- `fill_start` outside IDLE is ignored (not queued). `req_ready=0` outside IDLE.
- Every return to IDLE leaves one cycle with `ram_ena=0`. This is the bus turnaround between RAM-driven reads and controller-driven writes.
- `rsp_valid` is asserted for reads only. Writes give no response.

## Timing
- Write: accept at edge N; WR cycle between N and N+1; RAM stores at edge N+1. Next acceptance earliest at edge N+2.
- Read: accept at edge N; RD0 between N and N+1; RD1 between N+1 and N+2. `ram_data` is sampled at edge N+2. `rsp_valid=1` and `rsp_rdata` are valid between N+2 and N+3. Back-to-back read throughput is 1 per 3 cycles.
- Fill: 32 write cycles plus 1 IDLE cycle; `fill_done` high during that IDLE cycle.
- Reset values, all at the first edge with `rst=1`:
  - state IDLE
  - `ram_ena=0`, `ram_wena=0`, `ram_addr=0`, bus high-Z
  - `req_ready=1`
  - `rsp_valid=0`, `rsp_rdata=0`
  - `fill_done=0`
  - `busy=0`
  - fill counter 0
- Reset mid-read or mid-fill abandons the operation: no `rsp_valid` and no `fill_done`. Words already written stay written.

## Structure
- Package `ram2_pkg`: state enum (IDLE, WR, RD0, RD1, FILL), `ADDR_W`/`DATA_W` defaults, depth constant.
- Single module, no sub-modules. The tristate driver is one continuous assign in `ram2_ctrl`.
- The bench instantiates `ram2_ctrl` and `ram2` together.

## Test plan
- After reset, check all outputs at their reset values and `ram_data` high-Z.
- Write 0x12345678 at 0x00, then read 0x00 -> `rsp_valid` pulse at edge N+2 from read accept, `rsp_rdata=0x12345678`.
- Write 0xA5A5A5A5 at 0x01 and 0x77777777 at 0x1b, then read both back -> values match. Check the `ram_ena=0` gap between each operation and that there is no bus contention (no X on `ram_data`).
- `fill_start` with `fill_pattern=0xFFFFFFF0` -> 32 writes. Readback gives addr 0 = 0xFFFFFFF0, addr 15 = 0xFFFFFFFF, addr 16 = 0x00000000, addr 31 = 0x0000000F. `fill_done` pulses once, 33 cycles after start.
- `fill_start` and a read request in the same IDLE cycle -> fill runs first; the read is accepted only after `fill_done` and returns the filled value.
- Assert `rst` during RD1 and separately at fill word 10 -> no `rsp_valid`/`fill_done`. Words 0-9 hold the pattern; word 10 onward keep their prior contents.
